// File: rtl/recovery_sequencer.sv
// recovery_sequencer: sequences branch-mispredict recovery (hold, drain, flush, redirect)
// Optional feature macro: RECOV_PERF_EN adds recov_count / recov_cycles counters.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   mispredict_in       single-cycle mispredict pulse, accepted only in IDLE
//   target_pc           corrected PC, latched with an accepted mispredict
//   store_busy          committed store still writing data memory
//   flush               clears ROB, RSs, LSQ and FU pipelines
//   regstat_clear       one-cycle pulse in the first flush cycle
//   fetch_hold          stalls fetch from DRAIN through REDIRECT
//   redirect_valid      one-cycle pulse loading redirect_pc into fetch
//   redirect_pc         latched target_pc
//   busy                recovery in progress
//   drain_timeout       sticky flag: a store drain timed out
//   recov_count         (RECOV_PERF_EN) accepted mispredicts, saturating
//   recov_cycles        (RECOV_PERF_EN) busy cycles, saturating
module recovery_sequencer #(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mispredict_in,
    input  logic [31:0] target_pc,
    input  logic        store_busy,
    output logic        flush,
    output logic        regstat_clear,
    output logic        fetch_hold,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        drain_timeout
`ifdef RECOV_PERF_EN
    ,
    output logic [15:0] recov_count,
    output logic [15:0] recov_cycles
`endif
);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REDIRECT} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [31:0]   pc_q, pc_d;
    logic          to_q, to_d;
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (mispredict_in) begin
                state_d = DRAIN;
                pc_d    = target_pc;
                dcnt_d  = '0;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                // the incremented count is compared, so DRAIN lasts at most DRAIN_TIMEOUT cycles
                if (!store_busy || dcnt_d == DW'(DRAIN_TIMEOUT)) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                    to_d    = to_q | store_busy;
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == 4'(FLUSH_CYCLES - 1)) state_d = REDIRECT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            fcnt_q  <= '0;
            pc_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            to_q    <= to_d;
        end
    end
    assign busy           = state_q != IDLE;
    assign fetch_hold     = busy;
    assign flush          = state_q == FLUSH;
    assign regstat_clear  = flush && fcnt_q == 4'd0;
    assign redirect_valid = state_q == REDIRECT;
    assign redirect_pc    = pc_q;
    assign drain_timeout  = to_q;
`ifdef RECOV_PERF_EN
    logic [15:0] rcnt_q, rcyc_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q <= '0;
            rcyc_q <= '0;
        end else begin
            rcnt_q <= rcnt_q + 16'((state_q == IDLE && mispredict_in && rcnt_q != 16'hFFFF) ? 1 : 0);
            rcyc_q <= rcyc_q + 16'((busy && rcyc_q != 16'hFFFF) ? 1 : 0);
        end
    end
    assign recov_count  = rcnt_q;
    assign recov_cycles = rcyc_q;
`endif
endmodule

// File: tb/tb_recovery_sequencer.sv
// tb_recovery_sequencer: scoreboard bench for recovery_sequencer
module tb_recovery_sequencer;
    localparam int FC = 2;
    localparam int DT = 15;
    logic        clk = 0, reset = 1, mispredict_in = 0, store_busy = 0;
    logic [31:0] target_pc = 0;
    logic        flush, regstat_clear, fetch_hold, redirect_valid, busy, drain_timeout;
    logic [31:0] redirect_pc;
`ifdef RECOV_PERF_EN
    logic [15:0] recov_count, recov_cycles;
`endif
    recovery_sequencer #(.FLUSH_CYCLES(FC), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset), .mispredict_in(mispredict_in), .target_pc(target_pc),
        .store_busy(store_busy), .flush(flush), .regstat_clear(regstat_clear),
        .fetch_hold(fetch_hold), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .drain_timeout(drain_timeout)
`ifdef RECOV_PERF_EN
        , .recov_count(recov_count), .recov_cycles(recov_cycles)
`endif
    );
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;
    typedef struct {
        logic [31:0] pc;
        int unsigned t;
        int unsigned t_flush;
        int unsigned t_redir;
        logic        to;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic exp_to = 0;
    bit   sb_off = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    // monitor: tracks flush/hold windows, pops one expectation per redirect
    logic        prev_flush = 0;
    bit          after_redir = 0;
    int unsigned flush_rise = 0, flush_n = 0, rc_n = 0, hold_n = 0, redirs = 0, cur;
    always @(negedge clk) begin
        cur = cyc + 1;
        if (reset) begin
            prev_flush = 0; flush_n = 0; rc_n = 0; hold_n = 0; after_redir = 0; redirs = 0;
        end else begin
            if (after_redir) begin
                check("busy_after_redirect", {31'b0, busy}, 32'd0);
                after_redir = 0;
            end
            if (flush && !prev_flush) begin
                flush_rise = cur; flush_n = 0; rc_n = 0;
            end
            prev_flush = flush;
            if (flush) flush_n++;
            if (regstat_clear) rc_n++;
            hold_n = fetch_hold ? hold_n + 1 : 0;
            if (redirect_valid) begin
                redirs++;
                if (!sb_off) begin
                    after_redir = 1;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_redirect actual=pc %0h required=none", redirect_pc);
                    end else begin
                        e = q.pop_front();
                        check("redirect_pc", redirect_pc, e.pc);
                        check("redirect_cycle", cur, e.t_redir);
                        check("flush_rise_cycle", flush_rise, e.t_flush);
                        check("flush_len", flush_n, FC);
                        check("regstat_pulses", rc_n, 1);
                        check("hold_len", hold_n, e.t_redir - e.t);
                        check("drain_timeout_flag", {31'b0, drain_timeout}, {31'b0, e.to});
                    end
                end
            end
        end
    end
    task automatic issue(input logic [31:0] pc, input int w);
        exp_t x;
        int unsigned dr;
        x.t = cyc + 1;
        dr = (w >= DT) ? DT : w + 1;
        x.t_flush = x.t + 1 + dr;
        x.t_redir = x.t_flush + FC;
        exp_to = exp_to | (w >= DT);
        x.to = exp_to;
        x.pc = pc;
        q.push_back(x);
        mispredict_in = 1; target_pc = pc; store_busy = (w > 0);
        @(posedge clk); #1 mispredict_in = 0;
        repeat (w) @(posedge clk);
        #1 store_busy = 0;
    endtask
    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_idle actual=busy required=idle within 100 cycles");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1; q.delete(); exp_to = 0;
        @(posedge clk); #1 reset = 0;
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_flush"}, {31'b0, flush}, 0);
        check({tag, "_regstat_clear"}, {31'b0, regstat_clear}, 0);
        check({tag, "_fetch_hold"}, {31'b0, fetch_hold}, 0);
        check({tag, "_redirect_valid"}, {31'b0, redirect_valid}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
        check({tag, "_redirect_pc"}, redirect_pc, 0);
        check({tag, "_drain_timeout"}, {31'b0, drain_timeout}, 0);
    endtask
    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check_all_zero("reset");
        issue(32'h40, 0); wait_idle();
        check("redirect_pc_hold", redirect_pc, 32'h40);
        issue(32'h44, 3); wait_idle();
        check("drain_wait_no_timeout", {31'b0, drain_timeout}, 0);
        issue(32'h40, 0);
        @(posedge clk); #1 mispredict_in = 1; target_pc = 32'h80;
        @(posedge clk); #1 mispredict_in = 0;
        check("ignored_pc_kept", redirect_pc, 32'h40);
        wait_idle();
        issue(32'h100, 0);
        repeat (FC + 1) @(posedge clk);
        #1 mispredict_in = 1; target_pc = 32'h99;
        @(posedge clk); #1;
        issue(32'hC0, 0); wait_idle();
        check("back_to_back_pc", redirect_pc, 32'hC0);
        issue(32'h300, DT - 1); wait_idle();
        check("drain_edge_no_timeout", {31'b0, drain_timeout}, 0);
        issue(32'h200, DT); wait_idle();
        check("timeout_set", {31'b0, drain_timeout}, 1);
        issue(32'h204, 0); wait_idle();
        check("timeout_sticky", {31'b0, drain_timeout}, 1);
        do_reset();
        check("timeout_cleared", {31'b0, drain_timeout}, 0);
        issue(32'h400, 0);
        @(posedge clk); #1 reset = 1; q.delete(); exp_to = 0;
        @(posedge clk); #1 reset = 0;
        check_all_zero("mid_reset");
        repeat (12) @(posedge clk);
        #1;
`ifdef RECOV_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(32'h500 + 32'(i), 0); wait_idle();
        end
        check("recov_count_3", {16'b0, recov_count}, 3);
        check("recov_cycles_12", {16'b0, recov_cycles}, 12);
        sb_off = 1;
        mispredict_in = 1; store_busy = 1;
        for (int i = 0; i < 80000 && recov_cycles != 16'hFFFF; i++) begin
            @(posedge clk); #1;
        end
        repeat (60) @(posedge clk);
        #1 mispredict_in = 0; store_busy = 0;
        wait_idle();
        sb_off = 0;
        check("recov_cycles_sat", {16'b0, recov_cycles}, 32'hFFFF);
        check("recov_count_run", {16'b0, recov_count}, redirs);
`endif
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
